// File: rtl/frame_line_writer_if.sv
// rtl/frame_line_writer_if.sv - frame-buffer write port carrying one packed word per transfer
//
// Signals:
//   mem_wr_en    writer -> memory  word valid
//   mem_wr_ready memory -> writer  word accepted this cycle when high together with mem_wr_en
//   mem_wr_addr  writer -> memory  word address
//   mem_wr_data  writer -> memory  packed pixels, pixel k of the word in bits [3k+2:3k]
// Modports: master (the line writer), slave (the frame buffer).
interface frame_line_writer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 24
);
  logic              mem_wr_en;
  logic              mem_wr_ready;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;

  modport master (output mem_wr_en, output mem_wr_addr, output mem_wr_data, input mem_wr_ready);
  modport slave  (input mem_wr_en, input mem_wr_addr, input mem_wr_data, output mem_wr_ready);
endinterface

// File: rtl/frame_line_writer.sv
// rtl/frame_line_writer.sv - captures completed pixel lines and streams them into the frame buffer
//
// Ports:
//   clk, rst     single clock, asynchronous active-high reset
//   line_data    whole line from the receiver, pixel j in bits [3j+2:3j]
//   line_row     row number, meaningful while line_done is high
//   line_done    level from the receiver; each rising edge offers a new line
//   mem          frame-buffer write port (master side)
//   busy         high from capture until the last word of the row is accepted
//   row_written  one-cycle pulse per completed row
//   frame_done   pulses with row_written for the last row of the frame
//   drop_cnt     saturating count of lines refused (busy or row out of range)
module frame_line_writer #(
  parameter int Wight        = 640,
  parameter int Height       = 480,
  parameter int PIX_PER_WORD = 8,
  parameter int ADDR_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3*Wight-1:0]   line_data,
  input  logic [8:0]           line_row,
  input  logic                 line_done,
  frame_line_writer_if.master  mem,
  output logic                 busy,
  output logic                 row_written,
  output logic                 frame_done,
  output logic [7:0]           drop_cnt
);
  localparam int WORDS_PER_ROW = Wight / PIX_PER_WORD;
  localparam int WORD_W        = 3 * PIX_PER_WORD;
  localparam int IDX_W         = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_ROW - 1);
  localparam logic [8:0]       LAST_ROW = 9'(Height - 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FINISH} state_t;

  state_t               state;
  logic                 done_q;
  logic [IDX_W-1:0]     word_idx;
  logic [3*Wight-1:0]   line_q;
  logic [8:0]           row_q;

  logic                 start;
  logic                 row_ok;
  logic                 can_capture;
  logic                 drop;
  logic [IDX_W-1:0]     next_idx;

  // Address is formed wide enough for row*WORDS_PER_ROW before truncation.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [8:0] row, input logic [IDX_W-1:0] idx);
    return ADDR_W'(32'(row) * 32'(WORDS_PER_ROW) + 32'(idx));
  endfunction

  assign start    = line_done & ~done_q;
  assign row_ok   = 32'(line_row) < Height;
  // FINISH is not busy: a start arriving alongside row_written is taken.
  assign can_capture = (state != S_WRITE);
  assign drop     = start & (~can_capture | ~row_ok);
  assign next_idx = word_idx + IDX_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      done_q          <= 1'b0;
      word_idx        <= '0;
      line_q          <= '0;
      row_q           <= '0;
      mem.mem_wr_en   <= 1'b0;
      mem.mem_wr_addr <= '0;
      mem.mem_wr_data <= '0;
      busy            <= 1'b0;
      row_written     <= 1'b0;
      frame_done      <= 1'b0;
      drop_cnt        <= '0;
    end else begin
      done_q      <= line_done;
      row_written <= 1'b0;
      frame_done  <= 1'b0;

      case (state)
        S_WRITE: begin
          if (mem.mem_wr_ready) begin
            if (word_idx == LAST_IDX) begin
              state         <= S_FINISH;
              mem.mem_wr_en <= 1'b0;
              busy          <= 1'b0;
              row_written   <= 1'b1;
              frame_done    <= (row_q == LAST_ROW);
            end else begin
              // Word outputs are registered, so load the next word as this one is taken.
              word_idx        <= next_idx;
              mem.mem_wr_addr <= word_addr(row_q, next_idx);
              mem.mem_wr_data <= line_q[WORD_W*next_idx +: WORD_W];
            end
          end
        end
        default: begin
          state <= S_IDLE;
          if (start && row_ok) begin
            state           <= S_WRITE;
            line_q          <= line_data;
            row_q           <= line_row;
            word_idx        <= '0;
            mem.mem_wr_en   <= 1'b1;
            mem.mem_wr_addr <= word_addr(line_row, '0);
            mem.mem_wr_data <= line_data[WORD_W-1:0];
            busy            <= 1'b1;
          end
        end
      endcase

      if (drop && drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_frame_line_writer.sv
// tb/tb_frame_line_writer.sv - self-checking bench for frame_line_writer
module tb_frame_line_writer;
  localparam int W = 640, H = 480, PPW = 8, ADDR_W = 16, WPR = 80, DW = 24;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [3*W-1:0] line_data = '0;
  logic [8:0]     line_row = '0;
  logic           line_done = 1'b0;
  logic           busy, row_written, frame_done;
  logic [7:0]     drop_cnt;

  frame_line_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DW)) mem_if();

  frame_line_writer #(.Wight(W), .Height(H), .PIX_PER_WORD(PPW), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .line_data(line_data), .line_row(line_row), .line_done(line_done),
    .mem(mem_if), .busy(busy), .row_written(row_written), .frame_done(frame_done), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: pending words of the row in flight, frame flags per accepted row.
  logic [39:0] exp_q[$];
  bit          exp_fd_q[$];
  int          exp_drop = 0, exp_rows = 0;
  int          pix[W];
  int          cyc = 0, rise_cyc = 0, rw_cyc = 0, acc_count = 0, rw_count = 0;
  int          ready_mode = 0;
  logic [ADDR_W-1:0] last_addr = '0, hold_a = '0;
  logic [DW-1:0]     last_data = '0, hold_d = '0;
  bit                hold_v = 0;
  logic [39:0]       mon_e;

  always @(posedge clk) cyc++;

  initial begin
    mem_if.mem_wr_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      mem_if.mem_wr_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      hold_v = 0;
    end else begin
      if (hold_v) begin
        check("stall_en", mem_if.mem_wr_en, 1);
        check("stall_addr", mem_if.mem_wr_addr, hold_a);
        check("stall_data", mem_if.mem_wr_data, hold_d);
      end
      hold_v = mem_if.mem_wr_en && !mem_if.mem_wr_ready;
      hold_a = mem_if.mem_wr_addr;
      hold_d = mem_if.mem_wr_data;
      if (mem_if.mem_wr_en && mem_if.mem_wr_ready) begin
        acc_count++;
        last_addr = mem_if.mem_wr_addr;
        last_data = mem_if.mem_wr_data;
        if (exp_q.size() == 0) check("spurious_write", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", mem_if.mem_wr_addr, mon_e[39:24]);
          check("wr_data", mem_if.mem_wr_data, mon_e[23:0]);
        end
      end
      if (row_written) begin
        rw_count++;
        rw_cyc = cyc;
        if (exp_fd_q.size() == 0) check("spurious_row_written", 1, 0);
        else check("frame_done", frame_done, exp_fd_q.pop_front());
      end else if (frame_done) begin
        check("frame_done_alone", 1, 0);
      end
    end
  end

  task automatic fill_pix(input int mode);
    for (int j = 0; j < W; j++) pix[j] = (mode == 0) ? (j % 8) : int'($urandom_range(0, 7));
  endtask

  task automatic send_line(input int row);
    logic [DW-1:0] d;
    if (line_done) begin
      @(posedge clk); #1;
      line_done = 1'b0;
    end
    @(posedge clk); #1;
    for (int j = 0; j < W; j++) line_data[3*j +: 3] = 3'(pix[j]);
    line_row  = 9'(row);
    line_done = 1'b1;
    rise_cyc  = cyc;
    if (exp_q.size() == 0 && row < H) begin
      for (int w = 0; w < WPR; w++) begin
        d = '0;
        for (int k = 0; k < PPW; k++) d = d | (DW'(pix[w*PPW + k]) << (3*k));
        exp_q.push_back({16'(row*WPR + w), d});
      end
      exp_fd_q.push_back(row == H-1);
      exp_rows++;
    end else if (exp_drop < 255) begin
      exp_drop++;
    end
    @(posedge clk); #1;
    for (int j = 0; j < W; j++) line_data[3*j +: 3] = 3'($urandom);
    line_row = 9'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || exp_fd_q.size() != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 3000) check("timeout_idle", 1, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int base, n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_en", mem_if.mem_wr_en, 0);
    check("rst_addr", mem_if.mem_wr_addr, 0);
    check("rst_data", mem_if.mem_wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_row_written", row_written, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_drop", drop_cnt, 0);
    rst = 1'b0;

    // Single row 5, ready always high.
    fill_pix(0);
    send_line(5);
    check("cap_busy", busy, 1);
    check("cap_en", mem_if.mem_wr_en, 1);
    wait_idle();
    check("row5_latency", rw_cyc - rise_cyc, 81);
    check("row5_last_addr", last_addr, 479);
    check("row5_data", last_data, 24'hFAC688);
    check("row5_busy_low", busy, 0);

    // Backpressure on row 0.
    ready_mode = 1;
    fill_pix(1);
    base = acc_count;
    send_line(0);
    wait_idle();
    check("bp_count", acc_count - base, 80);
    check("bp_last_addr", last_addr, 79);

    // Last row of the frame.
    ready_mode = 0;
    fill_pix(1);
    send_line(H-1);
    wait_idle();
    check("last_addr", last_addr, 38399);

    // Out of range row, overlap, saturation.
    send_line(480);
    wait_idle();
    check("drop_oor", drop_cnt, 1);
    fill_pix(1);
    send_line(100);
    repeat (8) @(posedge clk);
    fill_pix(1);
    send_line(101);
    wait_idle();
    check("drop_overlap", drop_cnt, 2);
    for (int i = 0; i < 300; i++) send_line(480 + int'($urandom_range(0, 31)));
    wait_idle();
    check("drop_sat", drop_cnt, 255);
    check("rows_before_rst", rw_count, exp_rows);

    // Reset after 30 accepted words.
    fill_pix(1);
    base = acc_count;
    send_line(200);
    n = 0;
    while (acc_count - base < 30 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (n >= 200) check("timeout_rst_wait", 1, 0);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_en", mem_if.mem_wr_en, 0);
    check("mid_rst_addr", mem_if.mem_wr_addr, 0);
    check("mid_rst_data", mem_if.mem_wr_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_row_written", row_written, 0);
    check("mid_rst_frame_done", frame_done, 0);
    check("mid_rst_drop", drop_cnt, 0);
    exp_q.delete();
    exp_fd_q.delete();
    exp_drop  = 0;
    exp_rows  = rw_count;
    line_done = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    ready_mode = 1;
    fill_pix(1);
    base = acc_count;
    send_line(7);
    wait_idle();
    check("row7_count", acc_count - base, 80);
    check("row7_last_addr", last_addr, 639);

    // Randomized rows, ready patterns and overlapping starts.
    for (int it = 0; it < 8; it++) begin
      ready_mode = int'($urandom_range(0, 1));
      fill_pix(1);
      send_line(($urandom_range(0, 4) == 0) ? 480 + int'($urandom_range(0, 31)) : int'($urandom_range(0, H-1)));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 100)) @(posedge clk);
        fill_pix(1);
        send_line(int'($urandom_range(0, H-1)));
      end
      wait_idle();
      check("rand_drop", drop_cnt, exp_drop);
    end
    check("rows_total", rw_count, exp_rows);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
